me_sched: RTL and testbench

Sequencer for the 16-lane SAD motion-estimation core. It accepts one block job (block coordinates) at a time and issues the 8 current-block row reads and then the 16 previous-frame search-column reads. It delays the core control strobes to line up with the read-data latency, waits for the core's running minimum to settle, and presents the result on a valid/ready output port. It sits between the frame-buffer read port and the core, under the frame-level block walker.

---
 rtl/me_sched_if.sv | 47 ++++
 rtl/me_sched.sv | 154 +++++++++++++++
 tb/tb_me_sched.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/me_sched_if.sv
// me_sched_if: bundles the me_sched ports other than clk/rst.
//   job_*  : block job request (valid/ready) and its coordinates, plus abort
//   rd_*   : frame-buffer read strobe, frame select, row/column index, job coordinates
//   core_* : strobes to the SAD core (clear, load/keep) and its running-minimum result
//   res_*  : registered result (valid/ready) with SAD, motion vector and coordinates
//   busy   : scheduler is not idle
// master = scheduler side, slave = surrounding logic (walker, frame buffer, core, sink).
interface me_sched_if #(
    parameter int unsigned BX_W = 9,
    parameter int unsigned BY_W = 9
);
    logic            job_valid;
    logic            job_ready;
    logic [BX_W-1:0] job_bx;
    logic [BY_W-1:0] job_by;
    logic            abort;
    logic            rd_en;
    logic            rd_sel;
    logic [3:0]      rd_idx;
    logic [BX_W-1:0] rd_bx;
    logic [BY_W-1:0] rd_by;
    logic            core_rst;
    logic            core_keep;
    logic [13:0]     core_sad;
    logic [3:0]      core_mv_x;
    logic [3:0]      core_mv_y;
    logic            res_valid;
    logic            res_ready;
    logic [13:0]     res_sad;
    logic [3:0]      res_mv_x;
    logic [3:0]      res_mv_y;
    logic [BX_W-1:0] res_bx;
    logic [BY_W-1:0] res_by;
    logic            busy;

    modport master (
        input  job_valid, job_bx, job_by, abort, core_sad, core_mv_x, core_mv_y, res_ready,
        output job_ready, rd_en, rd_sel, rd_idx, rd_bx, rd_by, core_rst, core_keep,
               res_valid, res_sad, res_mv_x, res_mv_y, res_bx, res_by, busy
    );

    modport slave (
        output job_valid, job_bx, job_by, abort, core_sad, core_mv_x, core_mv_y, res_ready,
        input  job_ready, rd_en, rd_sel, rd_idx, rd_bx, rd_by, core_rst, core_keep,
               res_valid, res_sad, res_mv_x, res_mv_y, res_bx, res_by, busy
    );
endinterface

// File: rtl/me_sched.sv
// me_sched: job sequencer for the 16-lane SAD motion-estimation core.
// Accepts one block job, issues 8 current-block row reads then 16 search-column
// reads, lines the core strobes up with the read latency, waits for the core
// minimum to settle and holds the result on a valid/ready port.
// Ports:
//   clk : clock, posedge
//   rst : synchronous active-high reset
//   bus : me_sched_if.master (job, frame-buffer read, core control/result, result port, busy)
module me_sched #(
    parameter int unsigned RD_LAT   = 2,
    parameter int unsigned CORE_LAT = 1,
    parameter int unsigned BX_W     = 9,
    parameter int unsigned BY_W     = 9
) (
    input  logic       clk,
    input  logic       rst,
    me_sched_if.master bus
);
    localparam logic [4:0] DrainLast = 5'(RD_LAT + CORE_LAT - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StSearch, StDrain, StResult} state_e;

    state_e            r_state, w_state_nxt;
    logic [4:0]        r_cnt, w_cnt_nxt;
    logic [BX_W-1:0]   r_rd_bx;
    logic [BY_W-1:0]   r_rd_by;
    logic [13:0]       r_res_sad;
    logic [3:0]        r_res_mv_x, r_res_mv_y;
    logic [BX_W-1:0]   r_res_bx;
    logic [BY_W-1:0]   r_res_by;
    // Issue-side tags delayed by the read latency; MSB lines up with data at the core.
    logic [RD_LAT-1:0] r_dl_start, r_dl_load;

    logic w_accept, w_abort, w_drain_done, w_tag_load;

    assign w_accept     = (r_state == StIdle) && bus.job_valid;
    assign w_abort      = bus.abort && (r_state inside {StLoad, StSearch, StDrain});
    assign w_drain_done = (r_state == StDrain) && (r_cnt == DrainLast);
    assign w_tag_load   = (r_state == StLoad);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_nxt = StLoad;
                    w_cnt_nxt   = 5'd0;
                end
            end
            StLoad: begin
                if (r_cnt == 5'd7) begin
                    w_state_nxt = StSearch;
                    w_cnt_nxt   = 5'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 5'd1;
                end
            end
            StSearch: begin
                if (r_cnt == 5'd15) begin
                    w_state_nxt = StDrain;
                    w_cnt_nxt   = 5'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 5'd1;
                end
            end
            StDrain: begin
                if (r_cnt == DrainLast) begin
                    w_state_nxt = StResult;
                    w_cnt_nxt   = 5'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 5'd1;
                end
            end
            StResult: begin
                if (bus.res_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = 5'd0;
            end
        endcase
        if (w_abort) begin
            w_state_nxt = StIdle;
            w_cnt_nxt   = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_bx <= '0;
            r_rd_by <= '0;
        end else if (w_accept) begin
            r_rd_bx <= bus.job_bx;
            r_rd_by <= bus.job_by;
        end
    end

    // Core minimum is final in the last drain cycle; capture it there and hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_sad  <= '0;
            r_res_mv_x <= '0;
            r_res_mv_y <= '0;
            r_res_bx   <= '0;
            r_res_by   <= '0;
        end else if (w_drain_done) begin
            r_res_sad  <= bus.core_sad;
            r_res_mv_x <= bus.core_mv_x;
            r_res_mv_y <= bus.core_mv_y;
            r_res_bx   <= r_rd_bx;
            r_res_by   <= r_rd_by;
        end
    end

    // Start tag enters on the accept cycle so it exits one cycle ahead of the first load data.
    always_ff @(posedge clk) begin
        if (rst || w_abort) begin
            r_dl_start <= '0;
            r_dl_load  <= '0;
        end else begin
            r_dl_start <= (r_dl_start << 1) | RD_LAT'(w_accept);
            r_dl_load  <= (r_dl_load << 1) | RD_LAT'(w_tag_load);
        end
    end

    assign bus.job_ready = (r_state == StIdle) && !rst;
    assign bus.rd_en     = (r_state == StLoad) || (r_state == StSearch);
    assign bus.rd_sel    = (r_state == StSearch);
    assign bus.rd_idx    = bus.rd_en ? r_cnt[3:0] : 4'd0;
    assign bus.rd_bx     = r_rd_bx;
    assign bus.rd_by     = r_rd_by;
    assign bus.core_rst  = rst || r_dl_start[RD_LAT-1];
    assign bus.core_keep = rst || !r_dl_load[RD_LAT-1];
    assign bus.res_valid = (r_state == StResult);
    assign bus.res_sad   = r_res_sad;
    assign bus.res_mv_x  = r_res_mv_x;
    assign bus.res_mv_y  = r_res_mv_y;
    assign bus.res_bx    = r_res_bx;
    assign bus.res_by    = r_res_by;
    assign bus.busy      = (r_state != StIdle);
endmodule

// File: tb/tb_me_sched.sv
// tb_me_sched: directed bench for me_sched. DUT a runs at RD_LAT=2/CORE_LAT=1,
// DUT b at RD_LAT=4/CORE_LAT=2; both share clk and rst. Cycle k=0 is the cycle
// in which job_valid && job_ready holds; inputs change 1 time unit after posedge
// and outputs are sampled on the negedge.
module tb_me_sched;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cur_k    = 0;

    always #5 clk = ~clk;

    me_sched_if #(.BX_W(9), .BY_W(9)) a_if ();
    me_sched_if #(.BX_W(9), .BY_W(9)) b_if ();

    me_sched #(.RD_LAT(2), .CORE_LAT(1), .BX_W(9), .BY_W(9)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    me_sched #(.RD_LAT(4), .CORE_LAT(2), .BX_W(9), .BY_W(9)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s (k=%0d): got 0x%0h, expected 0x%0h", tag, cur_k, obs, exp_v);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Full default-latency job on DUT a with res_ready high; checks every cycle k=0..29.
    task automatic run_full(input logic [8:0] bx, input logic [8:0] by, input logic [13:0] sad,
                            input logic [3:0] mx, input logic [3:0] my);
        logic [3:0] e_idx;
        a_if.job_valid = 1'b1;
        a_if.job_bx    = bx;
        a_if.job_by    = by;
        a_if.core_sad  = sad;
        a_if.core_mv_x = mx;
        a_if.core_mv_y = my;
        a_if.res_ready = 1'b1;
        for (int k = 0; k <= 29; k++) begin
            @(negedge clk);
            cur_k = k;
            e_idx = (k >= 1 && k <= 8) ? 4'(k - 1) : (k >= 9 && k <= 24) ? 4'(k - 9) : 4'd0;
            check("rd_en", a_if.rd_en, (k >= 1 && k <= 24));
            check("rd_sel", a_if.rd_sel, (k >= 9 && k <= 24));
            check("rd_idx", a_if.rd_idx, e_idx);
            check("core_rst", a_if.core_rst, (k == 2));
            check("core_keep", a_if.core_keep, !(k >= 3 && k <= 10));
            check("res_valid", a_if.res_valid, (k == 28));
            check("busy", a_if.busy, (k >= 1 && k <= 28));
            check("job_ready", a_if.job_ready, (k == 0 || k == 29));
            if (k == 1) begin
                check("rd_bx", a_if.rd_bx, bx);
                check("rd_by", a_if.rd_by, by);
            end
            if (k == 28) begin
                check("res_sad", a_if.res_sad, sad);
                check("res_mv_x", a_if.res_mv_x, mx);
                check("res_mv_y", a_if.res_mv_y, my);
                check("res_bx", a_if.res_bx, bx);
                check("res_by", a_if.res_by, by);
            end
            next_cycle();
            a_if.job_valid = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        a_if.job_valid = 1'b0; a_if.job_bx = '0; a_if.job_by = '0; a_if.abort = 1'b0;
        a_if.core_sad = '0; a_if.core_mv_x = '0; a_if.core_mv_y = '0; a_if.res_ready = 1'b0;
        b_if.job_valid = 1'b0; b_if.job_bx = '0; b_if.job_by = '0; b_if.abort = 1'b0;
        b_if.core_sad = '0; b_if.core_mv_x = '0; b_if.core_mv_y = '0; b_if.res_ready = 1'b0;

        // Reset values
        repeat (2) next_cycle();
        @(negedge clk);
        check("rst_job_ready", a_if.job_ready, 1'b0);
        check("rst_core_rst", a_if.core_rst, 1'b1);
        check("rst_core_keep", a_if.core_keep, 1'b1);
        check("rst_rd_en", a_if.rd_en, 1'b0);
        check("rst_rd_idx", a_if.rd_idx, 4'd0);
        check("rst_res_valid", a_if.res_valid, 1'b0);
        check("rst_res_sad", a_if.res_sad, 14'd0);
        check("rst_busy", a_if.busy, 1'b0);
        check("rst_b_core_rst", b_if.core_rst, 1'b1);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_job_ready", a_if.job_ready, 1'b1);
        check("post_rst_core_rst", a_if.core_rst, 1'b0);
        next_cycle();

        // Single job at defaults
        run_full(9'd5, 9'd3, 14'h01A4, 4'd3, 4'd12);

        // Backpressure with a second job held pending
        a_if.job_valid = 1'b1; a_if.job_bx = 9'd17; a_if.job_by = 9'd200;
        a_if.core_sad = 14'h02B7; a_if.core_mv_x = 4'd1; a_if.core_mv_y = 4'd15;
        a_if.res_ready = 1'b0;
        for (int k = 0; k <= 68; k++) begin
            if (k == 1) begin
                a_if.job_bx = 9'd9;
                a_if.job_by = 9'd9;
            end
            if (k == 30) begin
                a_if.core_sad = 14'h0ABC; a_if.core_mv_x = 4'd7; a_if.core_mv_y = 4'd7;
            end
            if (k == 38) a_if.res_ready = 1'b1;
            if (k == 40) begin
                a_if.job_valid = 1'b0;
                a_if.core_sad  = 14'h0055;
            end
            @(negedge clk);
            cur_k = k;
            if (k >= 1 && k <= 38) check("bp_job_ready_low", a_if.job_ready, 1'b0);
            if (k >= 28 && k <= 38) begin
                check("bp_res_valid", a_if.res_valid, 1'b1);
                check("bp_res_sad", a_if.res_sad, 14'h02B7);
                check("bp_res_mv_x", a_if.res_mv_x, 4'd1);
                check("bp_res_mv_y", a_if.res_mv_y, 4'd15);
                check("bp_res_bx", a_if.res_bx, 9'd17);
                check("bp_res_by", a_if.res_by, 9'd200);
            end
            if (k == 39) begin
                check("bp_idle_job_ready", a_if.job_ready, 1'b1);
                check("bp_idle_res_valid", a_if.res_valid, 1'b0);
                check("bp_idle_busy", a_if.busy, 1'b0);
            end
            if (k == 40) begin
                check("bp_j2_busy", a_if.busy, 1'b1);
                check("bp_j2_rd_en", a_if.rd_en, 1'b1);
                check("bp_j2_rd_idx", a_if.rd_idx, 4'd0);
                check("bp_j2_rd_bx", a_if.rd_bx, 9'd9);
            end
            if (k >= 40 && k <= 66) check("bp_j2_no_res", a_if.res_valid, 1'b0);
            if (k == 67) begin
                check("bp_j2_res_valid", a_if.res_valid, 1'b1);
                check("bp_j2_res_sad", a_if.res_sad, 14'h0055);
                check("bp_j2_res_bx", a_if.res_bx, 9'd9);
            end
            if (k == 68) check("bp_j2_res_done", a_if.res_valid, 1'b0);
            next_cycle();
        end

        // Back-to-back jobs, one accept every 29 cycles
        a_if.job_valid = 1'b1; a_if.job_bx = 9'd100; a_if.job_by = 9'd50;
        a_if.core_sad = 14'h0111; a_if.res_ready = 1'b1;
        for (int k = 0; k <= 58; k++) begin
            if (k == 1) begin
                a_if.job_bx = 9'd479;
                a_if.job_by = 9'd269;
            end
            if (k == 28) a_if.core_sad = 14'h0222;
            if (k == 30) a_if.job_valid = 1'b0;
            @(negedge clk);
            cur_k = k;
            check("b2b_job_ready", a_if.job_ready, (k == 0 || k == 29 || k == 58));
            check("b2b_res_valid", a_if.res_valid, (k == 28 || k == 57));
            if (k == 28) begin
                check("b2b_r1_bx", a_if.res_bx, 9'd100);
                check("b2b_r1_by", a_if.res_by, 9'd50);
                check("b2b_r1_sad", a_if.res_sad, 14'h0111);
            end
            if (k == 30) check("b2b_j2_rd_bx", a_if.rd_bx, 9'd479);
            if (k == 57) begin
                check("b2b_r2_bx", a_if.res_bx, 9'd479);
                check("b2b_r2_by", a_if.res_by, 9'd269);
                check("b2b_r2_sad", a_if.res_sad, 14'h0222);
            end
            next_cycle();
        end

        // Abort in SEARCH at rd_idx=6
        a_if.job_valid = 1'b1; a_if.job_bx = 9'd33; a_if.job_by = 9'd44;
        a_if.core_sad = 14'h0333;
        for (int k = 0; k <= 35; k++) begin
            if (k == 1) a_if.job_valid = 1'b0;
            if (k == 15) a_if.abort = 1'b1;
            if (k == 16) a_if.abort = 1'b0;
            @(negedge clk);
            cur_k = k;
            if (k == 15) begin
                check("ab_rd_sel", a_if.rd_sel, 1'b1);
                check("ab_rd_idx", a_if.rd_idx, 4'd6);
            end
            if (k == 16) begin
                check("ab_rd_en", a_if.rd_en, 1'b0);
                check("ab_job_ready", a_if.job_ready, 1'b1);
                check("ab_busy", a_if.busy, 1'b0);
                check("ab_core_keep", a_if.core_keep, 1'b1);
            end
            if (k >= 16) check("ab_no_res", a_if.res_valid, 1'b0);
            next_cycle();
        end
        run_full(9'd7, 9'd8, 14'h0777, 4'd2, 4'd5);

        // Reset mid-DRAIN
        a_if.job_valid = 1'b1; a_if.job_bx = 9'd1; a_if.job_by = 9'd2;
        a_if.core_sad = 14'h0100;
        for (int k = 0; k <= 32; k++) begin
            if (k == 1) a_if.job_valid = 1'b0;
            if (k == 26) rst = 1'b1;
            if (k == 27) rst = 1'b0;
            @(negedge clk);
            cur_k = k;
            if (k == 26) begin
                check("rd_core_rst_in_rst", a_if.core_rst, 1'b1);
                check("rd_job_ready_in_rst", a_if.job_ready, 1'b0);
            end
            if (k == 27) begin
                check("rd_rd_en", a_if.rd_en, 1'b0);
                check("rd_rd_sel", a_if.rd_sel, 1'b0);
                check("rd_rd_idx", a_if.rd_idx, 4'd0);
                check("rd_rd_bx", a_if.rd_bx, 9'd0);
                check("rd_rd_by", a_if.rd_by, 9'd0);
                check("rd_core_rst", a_if.core_rst, 1'b0);
                check("rd_core_keep", a_if.core_keep, 1'b1);
                check("rd_res_sad", a_if.res_sad, 14'd0);
                check("rd_res_bx", a_if.res_bx, 9'd0);
                check("rd_busy", a_if.busy, 1'b0);
                check("rd_job_ready", a_if.job_ready, 1'b1);
            end
            if (k >= 27) check("rd_no_res", a_if.res_valid, 1'b0);
            next_cycle();
        end

        // Reset mid-RESULT
        a_if.job_valid = 1'b1; a_if.job_bx = 9'd3; a_if.job_by = 9'd4;
        a_if.core_sad = 14'h0200; a_if.res_ready = 1'b0;
        for (int k = 0; k <= 34; k++) begin
            if (k == 1) a_if.job_valid = 1'b0;
            if (k == 30) rst = 1'b1;
            if (k == 31) begin
                rst = 1'b0;
                a_if.res_ready = 1'b1;
            end
            @(negedge clk);
            cur_k = k;
            if (k == 28) begin
                check("rr_res_valid_pre", a_if.res_valid, 1'b1);
                check("rr_res_sad_pre", a_if.res_sad, 14'h0200);
            end
            if (k == 31) begin
                check("rr_res_sad", a_if.res_sad, 14'd0);
                check("rr_res_mv_x", a_if.res_mv_x, 4'd0);
                check("rr_res_bx", a_if.res_bx, 9'd0);
                check("rr_res_by", a_if.res_by, 9'd0);
                check("rr_rd_bx", a_if.rd_bx, 9'd0);
                check("rr_busy", a_if.busy, 1'b0);
                check("rr_job_ready", a_if.job_ready, 1'b1);
            end
            if (k >= 31) check("rr_no_res", a_if.res_valid, 1'b0);
            next_cycle();
        end

        // RD_LAT=4, CORE_LAT=2
        b_if.job_valid = 1'b1; b_if.job_bx = 9'd6; b_if.job_by = 9'd7;
        b_if.core_sad = 14'h0ABC; b_if.res_ready = 1'b1;
        for (int k = 0; k <= 33; k++) begin
            if (k == 1) b_if.job_valid = 1'b0;
            @(negedge clk);
            cur_k = k;
            check("lat4_rd_en", b_if.rd_en, (k >= 1 && k <= 24));
            check("lat4_core_rst", b_if.core_rst, (k == 4));
            check("lat4_core_keep", b_if.core_keep, !(k >= 5 && k <= 12));
            check("lat4_res_valid", b_if.res_valid, (k == 31));
            if (k == 31) begin
                check("lat4_res_sad", b_if.res_sad, 14'h0ABC);
                check("lat4_res_bx", b_if.res_bx, 9'd6);
                check("lat4_res_by", b_if.res_by, 9'd7);
            end
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
